// File: rtl/mem_access_unit_if.sv
// Pipeline request/response and word-wide data memory port bundle.
// slave = the access unit; master = pipeline plus memory side.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_op;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic [1:0]  resp_err;
  logic [31:0] address;
  logic [31:0] writeData;
  logic        memRead;
  logic        memWrite;
  logic [31:0] readData;
  logic        memStall;

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_addr,
    input  req_wdata,
    input  readData,
    input  memStall,
    output req_ready,
    output resp_valid,
    output resp_rdata,
    output resp_err,
    output address,
    output writeData,
    output memRead,
    output memWrite
  );

  modport master (
    output req_valid,
    output req_op,
    output req_addr,
    output req_wdata,
    output readData,
    output memStall,
    input  req_ready,
    input  resp_valid,
    input  resp_rdata,
    input  resp_err,
    input  address,
    input  writeData,
    input  memRead,
    input  memWrite
  );
endinterface

// File: rtl/mem_access_unit.sv
// MIPS load/store initiator for a word-only data memory port.
// Big-endian lanes; sub-word stores done as read-modify-write.
module mem_access_unit #(
  parameter int unsigned TIMEOUT = 1024
) (
  input logic              clk,
  input logic              rst,
  mem_access_unit_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_WR,
    S_RMW_RD,
    S_RMW_WR,
    S_RESP
  } state_t;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;

  state_t      state_q;
  logic [2:0]  op_q;
  logic [1:0]  off_q;
  logic [29:0] wadr_q;
  logic [31:0] wdata_q;
  logic [31:0] cnt_q;
  logic        rd_q;
  logic        wr_q;
  logic [31:0] wd_q;
  logic        ready_q;
  logic        rvalid_q;
  logic [31:0] rdata_q;
  logic [1:0]  err_q;

  logic        mis_d;
  logic        is_ld_d;
  logic        done_d;
  logic        abort_d;
  logic [31:0] ld_d;
  logic [31:0] mrg_d;
  logic [31:0] shl;
  logic [31:0] mask;
  logic [31:0] lane;

  always_comb begin
    mis_d = 1'b0;
    unique case (bus.req_op)
      OP_LW, OP_SW:         mis_d = bus.req_addr[1:0] != 2'b00;
      OP_LH, OP_LHU, OP_SH: mis_d = bus.req_addr[0];
      default:              mis_d = 1'b0;
    endcase
    is_ld_d = bus.req_op <= OP_LBU;
  end

  // Shifting left puts the addressed big-endian lane at the top.
  always_comb begin
    shl = bus.readData << {off_q, 3'b000};
    unique case (op_q)
      OP_LH:   ld_d = {{16{shl[31]}}, shl[31:16]};
      OP_LHU:  ld_d = {16'h0, shl[31:16]};
      OP_LB:   ld_d = {{24{shl[31]}}, shl[31:24]};
      OP_LBU:  ld_d = {24'h0, shl[31:24]};
      default: ld_d = bus.readData;
    endcase
    if (op_q == OP_SH) begin
      mask = 32'hFFFF_0000 >> {off_q, 3'b000};
      lane = {wdata_q[15:0], 16'h0} >> {off_q, 3'b000};
    end else begin
      mask = 32'hFF00_0000 >> {off_q, 3'b000};
      lane = {wdata_q[7:0], 24'h0} >> {off_q, 3'b000};
    end
    mrg_d = (bus.readData & ~mask) | lane;
  end

  assign done_d  = ~bus.memStall;
  assign abort_d = (TIMEOUT != 0) && bus.memStall
                && (cnt_q == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 3'd0;
      off_q    <= 2'd0;
      wadr_q   <= 30'd0;
      wdata_q  <= 32'd0;
      cnt_q    <= 32'd0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      wd_q     <= 32'd0;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rdata_q  <= 32'd0;
      err_q    <= 2'd0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.req_valid) begin
            op_q    <= bus.req_op;
            off_q   <= bus.req_addr[1:0];
            wadr_q  <= bus.req_addr[31:2];
            wdata_q <= bus.req_wdata;
            cnt_q   <= 32'd0;
            ready_q <= 1'b0;
            unique case (1'b1)
              mis_d: begin
                err_q    <= 2'b01;
                rvalid_q <= 1'b1;
                state_q  <= S_RESP;
              end
              (!mis_d && is_ld_d): begin
                rd_q    <= 1'b1;
                state_q <= S_RD;
              end
              (!mis_d && bus.req_op == OP_SW): begin
                wr_q    <= 1'b1;
                wd_q    <= bus.req_wdata;
                state_q <= S_WR;
              end
              default: begin
                rd_q    <= 1'b1;
                state_q <= S_RMW_RD;
              end
            endcase
          end
        end
        S_RESP: begin
          rvalid_q <= 1'b0;
          rdata_q  <= 32'd0;
          err_q    <= 2'd0;
          ready_q  <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: begin
          if (!done_d) begin
            cnt_q <= cnt_q + 32'd1;
            if (abort_d) begin
              rd_q     <= 1'b0;
              wr_q     <= 1'b0;
              err_q    <= 2'b10;
              rvalid_q <= 1'b1;
              state_q  <= S_RESP;
            end
          end else begin
            unique case (state_q)
              S_RD: begin
                rd_q     <= 1'b0;
                rdata_q  <= ld_d;
                rvalid_q <= 1'b1;
                state_q  <= S_RESP;
              end
              S_RMW_RD: begin
                rd_q    <= 1'b0;
                wr_q    <= 1'b1;
                wd_q    <= mrg_d;
                cnt_q   <= 32'd0;
                state_q <= S_RMW_WR;
              end
              default: begin
                wr_q     <= 1'b0;
                rvalid_q <= 1'b1;
                state_q  <= S_RESP;
              end
            endcase
          end
        end
      endcase
    end
  end

  assign bus.req_ready  = ready_q;
  assign bus.resp_valid = rvalid_q;
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.address    = {wadr_q, 2'b00};
  assign bus.writeData  = wd_q;
  assign bus.memRead    = rd_q;
  assign bus.memWrite   = wr_q;
endmodule
